// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with Mealy/Moore detect timing,
// optional overlap, an input-valid qualifier and a saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_W   = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_W-1:0]   RST_PAT = 8'b0000_1101,
  parameter int                 RST_LEN = 4,
  localparam int                LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cfg_moore,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             moore;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic             det_q;
  logic             rst_d;

  logic             accept;
  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] mask;
  logic             fill_ok;
  logic             hit;
  logic             len_ok;

  assign accept  = in_valid & ~cfg_load;
  assign shifted = PAT_W'({hist, i});
  assign fill_ok = ({1'b0, fill} + 1'b1) >= {1'b0, len};
  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

  always_comb begin
    mask = '0;
    for (int k = 0; k < PAT_W; k++) mask[k] = (k < int'(len));
  end

  // Suppressed during reset and the cycle after so out is quiet around reset.
  assign hit = accept & fill_ok & ~rst & ~rst_d & (((shifted ^ pattern) & mask) == '0);
  assign out = ~rst & (moore ? det_q : hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern   <= RST_PAT;
      len       <= LEN_W'(RST_LEN);
      overlap   <= 1'b1;
      moore     <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      det_q     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      rst_d     <= 1'b1;
    end else begin
      rst_d   <= 1'b0;
      cfg_err <= 1'b0;
      det_q   <= hit;

      if (cnt_clr)
        match_cnt <= '0;
      else if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + 1'b1;

      if (cfg_load) begin
        if (len_ok) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          moore   <= cfg_moore;
          hist    <= '0;
          fill    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (in_valid) begin
        hist <= shifted;
        // Non-overlap restarts the fill so the next match needs a full fresh pattern.
        if (!overlap && hit)
          fill <= '0;
        else if (fill < LEN_W'(PAT_W))
          fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; expected values are hand-computed.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             i;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cfg_moore;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(8'b0000_1101), .RST_LEN(4)) dut (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one bit after a falling edge, check the combinational out, advance a cycle.
  task automatic bit_chk(input string tag, input logic b, input logic v, input logic exp_o);
    i = b;
    in_valid = v;
    #1;
    chk(tag, {31'd0, out}, {31'd0, exp_o});
    @(negedge clk);
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] l,
                      input logic ov, input logic mo);
    cfg_pattern = pat;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_moore   = mo;
    cfg_load    = 1'b1;
    in_valid    = 1'b1;
    i           = 1'b1;
    #1;
    chk("load_out", {31'd0, out}, 32'd0);
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic clr();
    cnt_clr  = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    cnt_clr  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] s1, e1, s3, v3;
    logic [6:0] s2, e2a, e2b;
    logic [3:0] s6, e6;
    rst = 1'b1; i = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 1'b0; cfg_moore = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_cnt", {30'd0, match_cnt}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b0;

    // Test 1: default 1101 Mealy overlap
    s1 = 10'b1101001101;
    e1 = 10'b0001000001;
    for (int k = 9; k >= 0; k--) bit_chk("t1_out", s1[k], 1'b1, e1[k]);
    chk("t1_cnt", {30'd0, match_cnt}, 32'd2);
    clr();
    chk("t1_clr", {30'd0, match_cnt}, 32'd0);

    // Test 2: overlap vs non-overlap
    s2  = 7'b1101101;
    e2a = 7'b0001001;
    e2b = 7'b0001000;
    load(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    for (int k = 6; k >= 0; k--) bit_chk("t2_ovl", s2[k], 1'b1, e2a[k]);
    chk("t2_cnt_ovl", {30'd0, match_cnt}, 32'd2);
    clr();
    load(8'b0000_1101, 4'd4, 1'b0, 1'b0);
    for (int k = 6; k >= 0; k--) bit_chk("t2_novl", s2[k], 1'b1, e2b[k]);
    chk("t2_cnt_novl", {30'd0, match_cnt}, 32'd1);
    clr();

    // Test 3: 8-bit Moore pattern with bubbles
    load(8'b1010_0111, 4'd8, 1'b1, 1'b1);
    s3 = 10'b1011001011;
    v3 = 10'b1110111011;
    for (int k = 9; k >= 0; k--) bit_chk("t3_bits", s3[k], v3[k], 1'b0);
    bit_chk("t3_moore_pulse", 1'b0, 1'b0, 1'b1);
    bit_chk("t3_moore_after", 1'b0, 1'b0, 1'b0);
    chk("t3_cnt", {30'd0, match_cnt}, 32'd1);
    clr();

    // Test 4: rejected loads keep config
    load(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    chk("t4_err_valid", {31'd0, cfg_err}, 32'd0);
    load(8'b1111_1111, 4'd0, 1'b0, 1'b1);
    chk("t4_err_len0", {31'd0, cfg_err}, 32'd1);
    @(negedge clk);
    chk("t4_err_gone0", {31'd0, cfg_err}, 32'd0);
    load(8'b1111_1111, 4'd9, 1'b0, 1'b1);
    chk("t4_err_len9", {31'd0, cfg_err}, 32'd1);
    @(negedge clk);
    chk("t4_err_gone9", {31'd0, cfg_err}, 32'd0);
    s6 = 4'b1101;
    e6 = 4'b0001;
    for (int k = 3; k >= 0; k--) bit_chk("t4_kept", s6[k], 1'b1, e6[k]);
    chk("t4_cnt", {30'd0, match_cnt}, 32'd1);
    clr();

    // Test 5: counter saturation and clear priority
    load(8'b0000_0001, 4'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      bit_chk("t5_out", 1'b1, 1'b1, 1'b1);
      chk("t5_cnt", {30'd0, match_cnt}, (k < 3) ? k : 3);
    end
    bit_chk("t5_miss", 1'b0, 1'b1, 1'b0);
    chk("t5_hold", {30'd0, match_cnt}, 32'd3);
    cnt_clr = 1'b1;
    bit_chk("t5_clr_hit", 1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk("t5_clr_cnt", {30'd0, match_cnt}, 32'd0);

    // Test 6: reset mid-stream
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bit_chk("t6_pre", 1'b1, 1'b1, 1'b0);
    bit_chk("t6_pre", 1'b1, 1'b1, 1'b0);
    bit_chk("t6_pre", 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    bit_chk("t6_in_rst", 1'b1, 1'b1, 1'b0);
    chk("t6_rst_cnt", {30'd0, match_cnt}, 32'd0);
    rst = 1'b0;
    bit_chk("t6_post", 1'b1, 1'b1, 1'b0);
    load(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    for (int k = 3; k >= 0; k--) bit_chk("t6_fresh", s6[k], 1'b1, e6[k]);
    chk("t6_cnt", {30'd0, match_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial bit-pattern detector; successor to the fixed 4-bit Mealy "1101" detector.
- Pattern, pattern length, overlap mode and Mealy/Moore output timing are all configurable at runtime.
- Adds an input-valid qualifier and a saturating match counter with clear.
- Sits on a serial input stream and produces a detect strobe plus a match count for status logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2)
- CNT_W, 8, match counter width
- RST_PAT, 8'b0000_1101, pattern loaded at reset (low RST_LEN bits used)
- RST_LEN, 4, pattern length loaded at reset (1..PAT_W)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i  in  1  serial data bit
- in_valid  in  1  i is sampled only when high
- cfg_load  in  1  latch cfg_* fields this cycle
- cfg_pattern  in  PAT_W  new pattern; bit [len-1] is matched first, bit [0] last
- cfg_len  in  clog2(PAT_W+1)  new pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_moore  in  1  1 = registered (Moore) detect timing; 0 = Mealy
- cnt_clr  in  1  clear match counter
- out  out  1  detect strobe
- match_cnt  out  CNT_W  number of detections, saturating
- cfg_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (rst high at an edge):
  - pattern=RST_PAT, len=RST_LEN, overlap=1, moore=0.
  - hist=0, fill=0, match_cnt=0, cfg_err=0, registered detect=0.
  - out=0 while rst is high and in the first cycle after.
- State:
  - hist is a PAT_W-bit shift register of accepted bits; newest bit is at [0].
  - fill counts accepted bits and saturates at PAT_W.
- Accept: in_valid=1 and cfg_load=0. On accept, hist <= {hist[PAT_W-2:0], i}.
  - Non-overlap mode on a hit: fill <= 0.
  - Otherwise: fill <= min(fill+1, PAT_W).
- hit (combinational) is asserted when all of the following hold:
  - the cycle is an accept;
  - fill >= len-1;
  - the low len bits of {hist[PAT_W-2:0], i} equal the low len bits of pattern.
  - len=1 degenerates to hit = accept and (i == pattern[0]).
- out timing:
  - Mealy (moore=0): out = hit, in the same cycle, combinational from i and in_valid.
  - Moore (moore=1): out = hit registered; it is high for exactly the one cycle after the accepting edge.
- Mode change: a registered detect pending at a mode change still appears in the next cycle. Since cfg_load also blocks hit, no spurious pulse occurs.
- match_cnt: increments by 1 on the edge closing each hit cycle and holds at all-ones.
  - cnt_clr has priority: cnt_clr and hit in the same cycle gives match_cnt=0.
  - The count is unaffected by cfg_load.
- cfg_load:
  - If 1 <= cfg_len <= PAT_W: latch pattern, len, overlap and moore, and clear hist, fill and the registered detect. The i bit in that cycle is discarded and hit=0.
  - If cfg_len = 0 or cfg_len > PAT_W: config is unchanged, history is unchanged, the i bit is discarded, and cfg_err=1 in the next cycle.
- in_valid low: all detector state holds; out=0 in Mealy mode. In Moore mode a pending registered detect still shows for its one cycle.
- Reset mid-stream overrides everything and returns the reset config, discarding any programmed pattern.

Test Plan:
1. Reset defaults (1101, Mealy, overlap), in_valid=1, stream 1,1,0,1,0,0,1,1,0,1 -> out high combinationally during the 4th and 10th bits only; match_cnt=2.
2. Default config, stream 1,1,0,1,1,0,1:
   - overlap=1 -> hits on the 4th and 7th bits, match_cnt=2;
   - after reloading the same pattern with cfg_overlap=0 -> hit on the 4th bit only, match_cnt +1.
3. Load pattern 8'b1010_0111, len=8, moore=1, then stream that pattern -> out high exactly in the cycle after the 8th accepted bit; bubbles with in_valid=0 inserted mid-stream do not break the match.
4. Load with cfg_len=0, then cfg_len=9 -> cfg_err pulses one cycle each; stream 1101 afterwards -> still detected (config kept).
5. CNT_W=2, generate 5 hits -> match_cnt sequence 1,2,3,3,3; assert cnt_clr together with a hit -> 0.
6. rst asserted after bits 1,1,0 of 1101, released, then send 1 -> no hit; a fresh 1101 -> hit, match_cnt=1.
